uart_tx_frame: RTL and testbench
================================

// Module: uart_tx_frame
// PURPOSE
//  - UART transmitter; the counterpart of the receive path. Serialises one parallel word per frame:
//    start(0), DATA_WIDTH bits LSB first, optional parity, stop(1).
//  - Uses the same clk and prescale as the receiver, so one bit lasts prescale clk cycles and the
//    frame matches what the receiver samples. Sits between the host-side data source and the line.
// PARAMETERS
//  DATA_WIDTH   8   payload bits per frame
//  PRESCALE_W   6   width of prescale input
// PORTS
//  clk          in   1            single clock, all logic on rising edge
//  rst          in   1            asynchronous, active-high reset
//  p_data       in   DATA_WIDTH   word to send; captured on accept
//  data_valid   in   1            word request; accepted when data_valid & tx_ready
//  PAR_en       in   1            1 = parity bit inserted; captured on accept
//  PAR_typ      in   1            0 = even, 1 = odd; captured on accept
//  prescale     in   PRESCALE_W   clk cycles per bit; captured on accept; 0 is treated as 1
//  tx_out       out  1            serial line, idle high
//  busy         out  1            high while a frame is on the line
//  tx_ready     out  1            can accept a word this cycle
// BEHAVIOUR
//  - Reset values: tx_out=1, busy=0, tx_ready=1. FSM=IDLE. All counters and data registers are 0.
//  - Reset mid-frame: tx_out=1 immediately (async). The frame is truncated and not resumed.
//  - FSM: IDLE -> START -> DATA -> (PARITY if PAR_en latched) -> STOP -> IDLE,
//    or STOP -> START when a word is already accepted for the next frame.
//  - Accept: data_valid & tx_ready sampled at a rising edge. At that edge:
//      * p_data, PAR_en, PAR_typ and prescale are latched into the shift registers;
//      * parity = ^p_data ^ PAR_typ.
//  - Latency: tx_out=0 (start bit) and busy=1 from the edge of accept. Zero idle cycles.
//  - Edge counter 0..prescale-1 per bit; bit counter 0..DATA_WIDTH-1 in DATA. The state advances
//    when edge counter = prescale-1. Both counters wrap to 0 on every bit change.
//  - Frame length = (DATA_WIDTH+2+PAR_en)*prescale cycles, e.g. 8N1 at prescale 8 = 80 cycles.
//  - busy falls in the cycle after the last STOP cycle unless a next frame starts there.
//  - Input changes after accept have no effect on the current frame.
//  - data_valid while tx_ready=0: ignored; the source holds it until accepted.
// CONFIGURATION
//  UART_TX_HOLD_EN undefined:
//   - tx_ready = ~busy.
//   - Accept only in IDLE, so there is >=1 idle-high cycle between frames.
//  UART_TX_HOLD_EN defined:
//   - Adds a one-entry holding register (data, PAR_en, PAR_typ, prescale).
//   - tx_ready = holding register empty. Accept while busy fills the holding register.
//   - At the end of the last STOP cycle a held word is loaded straight into START:
//     back-to-back frames, no idle cycle, busy stays 1.
//   - Accept in the same cycle as a frame end, with the holding register empty: the word goes
//     directly to the shifter; that frame follows with no idle cycle.
//   - Reset clears the holding register.
// TESTING
//  1 prescale=8, PAR_en=1, PAR_typ=0, p_data=0xA5 -> tx_out per 8 cycles: 0,1,0,1,0,0,1,0,1,0(par),1;
//    busy high 88 cycles.
//  2 prescale=16, PAR_en=1, PAR_typ=1, p_data=0x07 -> parity bit 0 (3 ones, odd); frame 176 cycles.
//  3 PAR_en=0, prescale=4, p_data=0xFF -> 0 then nine 1s; 40 cycles; tx_ready=0 throughout;
//    data_valid pulsed mid-frame is ignored.
//  4 p_data changed to 0x00 one cycle after accepting 0x3C -> line still carries 0x3C bits.
//  5 rst pulsed at data bit 3 -> tx_out=1, busy=0 at once; the next accept starts a clean frame.
//  6 [UART_TX_HOLD_EN] accept 0x55, then 0xAA while busy -> tx_ready=0 until 0xAA loads;
//    0xAA start bit is in the cycle after the last 0x55 stop cycle.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmitter. Sends one parallel word per frame as
// start(0), DATA_WIDTH data bits LSB first, optional parity, stop(1).
// Each bit lasts prescale clk cycles (prescale 0 behaves as 1).
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   p_data      word to send, captured on accept
//   data_valid  word request, accepted when data_valid & tx_ready
//   PAR_en      1 = append parity bit, captured on accept
//   PAR_typ     0 = even, 1 = odd parity, captured on accept
//   prescale    clk cycles per bit, captured on accept
//   tx_out      serial line, idle high
//   busy        high while a frame is on the line
//   tx_ready    a word can be accepted this cycle
//
// Build option UART_TX_HOLD_EN: adds a one-entry holding register so a word
// can be accepted while a frame is in flight and sent back-to-back with no
// idle cycle. Without it, tx_ready = ~busy.
module uart_tx_frame #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE_W = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  PAR_en,
   input  logic                  PAR_typ,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic                  tx_out,
   output logic                  busy,
   output logic                  tx_ready
);

   localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state, state_n;
   logic [PRESCALE_W-1:0] cnt, cnt_n;
   logic [PRESCALE_W-1:0] ps_m1, ps_m1_n, in_ps_m1, ld_ps_m1;
   logic [BIT_W-1:0]      bit_idx, bit_idx_n;
   logic [DATA_WIDTH-1:0] shreg, shreg_n, ld_data;
   logic                  par_en, par_en_n, par_bit, par_bit_n;
   logic                  ld_par_en, ld_par_typ;
   logic                  tx_out_n, busy_n, tx_ready_n;
   logic                  accept, bit_end, load;

`ifdef UART_TX_HOLD_EN
   logic                  frame_end;
   logic                  hold_full, hold_full_n;
   logic [DATA_WIDTH-1:0] hold_data, hold_data_n;
   logic                  hold_par_en, hold_par_en_n, hold_par_typ, hold_par_typ_n;
   logic [PRESCALE_W-1:0] hold_ps_m1, hold_ps_m1_n;

   assign frame_end = (state == STOP) && bit_end;
`endif

   assign accept   = data_valid & tx_ready;
   assign bit_end  = (cnt == ps_m1);
   // Bit-end compare uses prescale-1; a prescale of 0 collapses to 1-cycle bits.
   assign in_ps_m1 = (prescale == '0) ? '0 : prescale - PRESCALE_W'(1);

   // Next-state, shifter and registered-output logic
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      bit_idx_n  = bit_idx;
      shreg_n    = shreg;
      par_en_n   = par_en;
      par_bit_n  = par_bit;
      ps_m1_n    = ps_m1;
      tx_out_n   = tx_out;
      busy_n     = busy;
      load       = 1'b0;
      ld_data    = p_data;
      ld_par_en  = PAR_en;
      ld_par_typ = PAR_typ;
      ld_ps_m1   = in_ps_m1;
`ifdef UART_TX_HOLD_EN
      hold_full_n    = hold_full;
      hold_data_n    = hold_data;
      hold_par_en_n  = hold_par_en;
      hold_par_typ_n = hold_par_typ;
      hold_ps_m1_n   = hold_ps_m1;
`endif

      if (state != IDLE) begin
         cnt_n = bit_end ? '0 : cnt + PRESCALE_W'(1);
      end

      // tx_out_n is the level of the bit being entered, so the line is registered
      case (state)
         START: begin
            if (bit_end) begin
               state_n   = DATA;
               bit_idx_n = '0;
               tx_out_n  = shreg[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == LAST_BIT) begin
                  bit_idx_n = '0;
                  if (par_en) begin
                     state_n  = PARITY;
                     tx_out_n = par_bit;
                  end else begin
                     state_n  = STOP;
                     tx_out_n = 1'b1;
                  end
               end else begin
                  bit_idx_n = bit_idx + BIT_W'(1);
                  shreg_n   = shreg >> 1;
                  tx_out_n  = shreg_n[0];
               end
            end
         end
         PARITY: begin
            if (bit_end) begin
               state_n  = STOP;
               tx_out_n = 1'b1;
            end
         end
         STOP: begin
            if (bit_end) begin
               state_n  = IDLE;
               tx_out_n = 1'b1;
               busy_n   = 1'b0;
            end
         end
         default: ;
      endcase

`ifdef UART_TX_HOLD_EN
      // A held word takes priority at frame end; tx_ready is 0 then, so no accept collides.
      if (frame_end && hold_full) begin
         load        = 1'b1;
         ld_data     = hold_data;
         ld_par_en   = hold_par_en;
         ld_par_typ  = hold_par_typ;
         ld_ps_m1    = hold_ps_m1;
         hold_full_n = 1'b0;
      end else if (accept) begin
         if ((state == IDLE) || frame_end) begin
            load = 1'b1;
         end else begin
            hold_full_n    = 1'b1;
            hold_data_n    = p_data;
            hold_par_en_n  = PAR_en;
            hold_par_typ_n = PAR_typ;
            hold_ps_m1_n   = in_ps_m1;
         end
      end
`else
      // tx_ready = ~busy, so an accept can only happen in IDLE
      load = accept;
`endif

      if (load) begin
         state_n   = START;
         cnt_n     = '0;
         bit_idx_n = '0;
         shreg_n   = ld_data;
         par_en_n  = ld_par_en;
         par_bit_n = (^ld_data) ^ ld_par_typ;
         ps_m1_n   = ld_ps_m1;
         tx_out_n  = 1'b0;
         busy_n    = 1'b1;
      end

`ifdef UART_TX_HOLD_EN
      tx_ready_n = ~hold_full_n;
`else
      tx_ready_n = ~busy_n;
`endif
   end

   // State and data registers; reset forces the line idle immediately
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
         par_en   <= 1'b0;
         par_bit  <= 1'b0;
         ps_m1    <= '0;
         tx_out   <= 1'b1;
         busy     <= 1'b0;
         tx_ready <= 1'b1;
`ifdef UART_TX_HOLD_EN
         hold_full    <= 1'b0;
         hold_data    <= '0;
         hold_par_en  <= 1'b0;
         hold_par_typ <= 1'b0;
         hold_ps_m1   <= '0;
`endif
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         bit_idx  <= bit_idx_n;
         shreg    <= shreg_n;
         par_en   <= par_en_n;
         par_bit  <= par_bit_n;
         ps_m1    <= ps_m1_n;
         tx_out   <= tx_out_n;
         busy     <= busy_n;
         tx_ready <= tx_ready_n;
`ifdef UART_TX_HOLD_EN
         hold_full    <= hold_full_n;
         hold_data    <= hold_data_n;
         hold_par_en  <= hold_par_en_n;
         hold_par_typ <= hold_par_typ_n;
         hold_ps_m1   <= hold_ps_m1_n;
`endif
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: scoreboard of expected frames, a line monitor
// that checks every bit slot cycle by cycle, and per-scenario tasks.
`timescale 1ns/1ps
module tb_uart_tx_frame;

   localparam int unsigned DW = 8;
   localparam int unsigned PW = 6;
`ifdef UART_TX_HOLD_EN
   localparam bit HOLD = 1'b1;
`else
   localparam bit HOLD = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] p_data;
   logic          data_valid, PAR_en, PAR_typ;
   logic [PW-1:0] prescale;
   logic          tx_out, busy, tx_ready;

   int          n_tests = 0;
   int          n_fail  = 0;
   int unsigned cyc     = 0;
   bit          mon_en  = 1'b1;

   typedef struct {
      logic [7:0] d;
      logic       pen;
      logic       ptyp;
      int         ps;
   } exp_t;

   exp_t        sb[$];
   int unsigned start_cyc[$];

   uart_tx_frame #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) dut (
      .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
      .PAR_en(PAR_en), .PAR_typ(PAR_typ), .prescale(prescale),
      .tx_out(tx_out), .busy(busy), .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin : watchdog
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
      $fatal(1, "watchdog expired");
   end

   // Line monitor: on a start edge pop the expected frame and check every cycle of every slot
   initial begin : monitor
      exp_t       e;
      logic       prev;
      logic [11:0] bits;
      int         nb, eps;
      logic       bad_bit, bad_busy, act;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (mon_en && prev && (tx_out === 1'b0)) begin
            start_cyc.push_back(cyc);
            if (sb.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_frame: start bit at cycle %0d, scoreboard empty (required no frame)", cyc);
            end else begin
               e    = sb.pop_front();
               eps  = (e.ps == 0) ? 1 : e.ps;
               bits = '1;
               bits[0]   = 1'b0;
               bits[8:1] = e.d;
               nb = e.pen ? 11 : 10;
               if (e.pen) bits[9] = (^e.d) ^ e.ptyp;
               bad_busy = 1'b0;
               for (int b = 0; b < nb; b++) begin
                  bad_bit = 1'b0;
                  act     = bits[b];
                  for (int c = 0; c < eps; c++) begin
                     if (b != 0 || c != 0) @(negedge clk);
                     if (tx_out !== bits[b]) begin bad_bit = 1'b1; act = tx_out; end
                     if (busy !== 1'b1) bad_busy = 1'b1;
                  end
                  n_tests++;
                  if (bad_bit) begin
                     n_fail++;
                     $display("FAIL frame_bit: word 0x%02h slot %0d line %b required %b", e.d, b, act, bits[b]);
                  end
               end
               n_tests++;
               if (bad_busy) begin
                  n_fail++;
                  $display("FAIL frame_busy: word 0x%02h busy went 0 inside frame, required 1", e.d);
               end
            end
         end
         prev = tx_out;
      end
   end

   // Offer a word, wait (bounded) for acceptance, then scramble inputs
   task automatic send(input logic [7:0] d, input logic pen, input logic ptyp,
                       input logic [PW-1:0] ps, input logic [7:0] d_after, input bit direct);
      exp_t e;
      int   guard;
      @(negedge clk);
      p_data = d; PAR_en = pen; PAR_typ = ptyp; prescale = ps; data_valid = 1'b1;
      guard = 0;
      while (tx_ready !== 1'b1 && guard < 3000) begin
         @(negedge clk);
         guard++;
      end
      n_tests++;
      if (guard >= 3000) begin
         n_fail++;
         $display("FAIL accept_timeout: tx_ready %b, required 1", tx_ready);
         data_valid = 1'b0;
         return;
      end
      e.d = d; e.pen = pen; e.ptyp = ptyp; e.ps = int'(ps);
      sb.push_back(e);
      @(negedge clk);
      data_valid = 1'b0;
      p_data     = d_after;
      PAR_en     = ~pen;
      PAR_typ    = ~ptyp;
      prescale   = ps + PW'(3);
      if (direct) begin
         n_tests++;
         if (tx_out !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_latency: word 0x%02h tx_out %b busy %b, required 0 1", d, tx_out, busy);
         end
      end
   endtask

   task automatic measure_busy(output int n);
      n = 0;
      while (busy === 1'b1 && n < 5000) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; data_valid = 1'b0; p_data = '0; PAR_en = 1'b0; PAR_typ = 1'b0; prescale = PW'(8);
      repeat (2) @(negedge clk);
      n_tests++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_state: tx_out %b busy %b tx_ready %b, required 1 0 1", tx_out, busy, tx_ready);
      end
      rst = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_after_reset: tx_out %b busy %b tx_ready %b, required 1 0 1", tx_out, busy, tx_ready);
      end
   endtask

   task automatic test_even_parity;
      int n;
      send(8'hA5, 1'b1, 1'b0, PW'(8), 8'h5A, 1'b1);
      measure_busy(n);
      n_tests++;
      if (n != 88 || tx_out !== 1'b1 || tx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL even_parity_len: busy %0d cycles tx_out %b tx_ready %b, required 88 1 1", n, tx_out, tx_ready);
      end
   endtask

   task automatic test_odd_parity;
      int n;
      send(8'h07, 1'b1, 1'b1, PW'(16), 8'hF8, 1'b1);
      measure_busy(n);
      n_tests++;
      if (n != 176) begin
         n_fail++;
         $display("FAIL odd_parity_len: busy %0d cycles, required 176", n);
      end
   endtask

   task automatic test_no_parity_ignore;
      int   n;
      bit   bad_rdy;
      logic rdy_seen;
      send(8'hFF, 1'b0, 1'b0, PW'(4), 8'hFF, 1'b1);
      n = 0; bad_rdy = 1'b0; rdy_seen = HOLD;
      while (busy === 1'b1 && n < 5000) begin
         if (tx_ready !== HOLD) begin bad_rdy = 1'b1; rdy_seen = tx_ready; end
         if (!HOLD && n == 10) begin p_data = 8'h12; data_valid = 1'b1; end
         if (n == 11) data_valid = 1'b0;
         n++;
         @(negedge clk);
      end
      n_tests++;
      if (n != 40) begin
         n_fail++;
         $display("FAIL no_parity_len: busy %0d cycles, required 40", n);
      end
      n_tests++;
      if (bad_rdy) begin
         n_fail++;
         $display("FAIL ready_in_frame: tx_ready %b during frame, required %b", rdy_seen, HOLD);
      end
      repeat (3) begin
         @(negedge clk);
         n_tests++;
         if (busy !== 1'b0 || tx_out !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_word: busy %b tx_out %b after frame, required 0 1", busy, tx_out);
         end
      end
   endtask

   task automatic test_capture;
      int n;
      send(8'h3C, 1'b1, 1'b0, PW'(6), 8'h00, 1'b1);
      measure_busy(n);
      n_tests++;
      if (n != 66) begin
         n_fail++;
         $display("FAIL capture_len: busy %0d cycles, required 66", n);
      end
   endtask

   task automatic test_prescale_zero;
      int n;
      send(8'h96, 1'b1, 1'b0, PW'(0), 8'h69, 1'b1);
      measure_busy(n);
      n_tests++;
      if (n != 11) begin
         n_fail++;
         $display("FAIL prescale_zero_len: busy %0d cycles, required 11", n);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      mon_en = 1'b0;
      send(8'h52, 1'b0, 1'b0, PW'(4), 8'h52, 1'b1);
      repeat (17) @(negedge clk);
      n_tests++;
      if (tx_out !== 1'b0 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL before_reset: data bit 3 tx_out %b busy %b, required 0 1", tx_out, busy);
      end
      rst = 1'b1;
      #1;
      n_tests++;
      if (tx_out !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL async_reset: tx_out %b busy %b tx_ready %b, required 1 0 1", tx_out, busy, tx_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      sb.delete();
      repeat (2) @(negedge clk);
      n_tests++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL no_resume: tx_out %b busy %b after reset, required 1 0", tx_out, busy);
      end
      mon_en = 1'b1;
      send(8'hC3, 1'b1, 1'b1, PW'(5), 8'h3C, 1'b1);
      measure_busy(n);
      n_tests++;
      if (n != 55) begin
         n_fail++;
         $display("FAIL clean_frame_len: busy %0d cycles, required 55", n);
      end
   endtask

   task automatic test_random;
      int         n, exp_len;
      logic [7:0] d;
      logic       pen, ptyp;
      int         ps;
      for (int i = 0; i < 4; i++) begin
         d = 8'($urandom); pen = 1'($urandom_range(0, 1)); ptyp = 1'($urandom_range(0, 1));
         ps = int'($urandom_range(1, 7));
         exp_len = (pen ? 11 : 10) * ps;
         send(d, pen, ptyp, PW'(ps), ~d, 1'b1);
         measure_busy(n);
         n_tests++;
         if (n != exp_len) begin
            n_fail++;
            $display("FAIL random_len: word 0x%02h busy %0d cycles, required %0d", d, n, exp_len);
         end
      end
   endtask

`ifdef UART_TX_HOLD_EN
   task automatic test_hold_back_to_back;
      int   n;
      bit   bad;
      logic seen;
      send(8'h55, 1'b0, 1'b0, PW'(4), 8'h00, 1'b1);
      send(8'hAA, 1'b0, 1'b0, PW'(4), 8'h00, 1'b0);
      bad = 1'b0; seen = 1'b0;
      for (int k = 2; k < 40; k++) begin
         if (tx_ready !== 1'b0) begin bad = 1'b1; seen = tx_ready; end
         @(negedge clk);
      end
      n_tests++;
      if (bad) begin
         n_fail++;
         $display("FAIL hold_ready: tx_ready %b while held, required 0", seen);
      end
      n_tests++;
      if (tx_ready !== 1'b1 || busy !== 1'b1 || tx_out !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_load: tx_ready %b busy %b tx_out %b, required 1 1 0", tx_ready, busy, tx_out);
      end
      n_tests++;
      if (start_cyc.size() < 2 || start_cyc[$] - start_cyc[$-1] != 40) begin
         n_fail++;
         $display("FAIL hold_gap: start spacing %0d, required 40",
                  (start_cyc.size() < 2) ? -1 : int'(start_cyc[$] - start_cyc[$-1]));
      end
      measure_busy(n);
      n_tests++;
      if (n != 40) begin
         n_fail++;
         $display("FAIL hold_second_len: busy %0d cycles, required 40", n);
      end
   endtask

   task automatic test_hold_frame_end;
      int n;
      send(8'h81, 1'b0, 1'b0, PW'(4), 8'h00, 1'b1);
      repeat (38) @(negedge clk);
      send(8'h7E, 1'b0, 1'b0, PW'(4), 8'h00, 1'b1);
      n_tests++;
      if (start_cyc.size() < 2 || start_cyc[$] - start_cyc[$-1] != 40) begin
         n_fail++;
         $display("FAIL frame_end_gap: start spacing %0d, required 40",
                  (start_cyc.size() < 2) ? -1 : int'(start_cyc[$] - start_cyc[$-1]));
      end
      measure_busy(n);
      n_tests++;
      if (n != 40) begin
         n_fail++;
         $display("FAIL frame_end_len: busy %0d cycles, required 40", n);
      end
   endtask
`else
   task automatic test_back_to_back;
      int n;
      send(8'h33, 1'b0, 1'b0, PW'(3), 8'h00, 1'b1);
      send(8'hCC, 1'b1, 1'b1, PW'(3), 8'h00, 1'b1);
      n_tests++;
      if (start_cyc.size() < 2 || start_cyc[$] - start_cyc[$-1] != 31) begin
         n_fail++;
         $display("FAIL idle_gap: start spacing %0d, required 31",
                  (start_cyc.size() < 2) ? -1 : int'(start_cyc[$] - start_cyc[$-1]));
      end
      measure_busy(n);
      n_tests++;
      if (n != 33) begin
         n_fail++;
         $display("FAIL second_len: busy %0d cycles, required 33", n);
      end
   endtask
`endif

   initial begin : main
      test_reset;
      test_even_parity;
      test_odd_parity;
      test_no_parity_ignore;
      test_capture;
      test_prescale_zero;
      test_reset_mid;
      test_random;
`ifdef UART_TX_HOLD_EN
      test_hold_back_to_back;
      test_hold_frame_end;
`else
      test_back_to_back;
`endif
      repeat (5) @(negedge clk);
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d frames never sent, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
